multiplier_control: RTL

Control FSM that sequences the shift-add two's-complement multiplier datapath: an X:A:B register chain, a 9-bit adder/subtractor and the switch operand S.
- Converts the Execute and ClearA_LoadB button levels into single-cycle datapath strobes: load, clear, add, subtract and shift.
- Runs exactly one WIDTH-step multiply per Execute press.
- Sits between the top-level button synchronizers and the datapath registers.

---
 rtl/multiplier_pkg.sv | 15 +
 rtl/multiplier_control.sv | 91 +++++++++
 2 files changed

// File: rtl/multiplier_pkg.sv
// Shared types and width for the shift-add multiplier controller.
package multiplier_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ADD,
    SHF,
    DONE,
    HOLD
  } ctrl_state_t;

endpackage

// File: rtl/multiplier_control.sv
// Sequencer for the X:A:B shift-add two's-complement multiplier:
// turns button levels into one-cycle load/clear/add/sub/shift strobes.
module multiplier_control
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Execute_h,
  input  logic                     ClearA_LoadB_h,
  input  logic                     M,
  output logic                     Ld_B,
  output logic                     Clr_AX,
  output logic                     Add,
  output logic                     Sub,
  output logic                     Shift,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(WIDTH)-1:0] Step
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  ctrl_state_t   r_state;
  ctrl_state_t   w_next;
  logic [SW-1:0] r_step;
  logic          w_last;

  assign w_last = (r_step == LAST);
  assign Step   = r_step;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_step  <= '0;
    end else begin
      r_state <= w_next;
      // Step only advances between steps; parked at 0 outside a run.
      if (r_state == SHF) begin
        if (!w_last) r_step <= r_step + SW'(1);
      end else if (r_state != ADD) begin
        r_step <= '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    Ld_B   = 1'b0;
    Clr_AX = 1'b0;
    Add    = 1'b0;
    Sub    = 1'b0;
    Shift  = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        Ld_B = ClearA_LoadB_h & ~Execute_h;
        if (Execute_h) w_next = CLR;
      end
      CLR: begin
        Clr_AX = 1'b1;
        Busy   = 1'b1;
        w_next = ADD;
      end
      ADD: begin
        Busy   = 1'b1;
        // Top bit carries negative weight: subtract instead of add.
        Add    = M & ~w_last;
        Sub    = M & w_last;
        w_next = SHF;
      end
      SHF: begin
        Shift  = 1'b1;
        Busy   = 1'b1;
        w_next = w_last ? DONE : ADD;
      end
      DONE: begin
        Done   = 1'b1;
        w_next = Execute_h ? HOLD : IDLE;
      end
      HOLD: begin
        if (!Execute_h) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
